line_memory_responder: RTL and testbench

//  Memory-side responder for the core's line-based memory port
//  (memoryAddr/Enable/IsWrite/WriteValue -> memoryReadValue/memoryDone).

---
 rtl/line_memory_responder.sv | 107 ++++++++++
 tb/tb_line_memory_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Line-wide memory responder: one full-line read or write per request,
// completed with a single-cycle done pulse a fixed number of cycles after acceptance.
module line_memory_responder #(
  parameter int unsigned AddrWidth = 30,
  parameter int unsigned LineWidth = 128,
  parameter int unsigned DepthLog2 = 12,
  parameter int unsigned Latency   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AddrWidth-1:0] memoryAddr,
  input  logic                 memoryEnable,
  input  logic                 memoryIsWrite,
  input  logic [LineWidth-1:0] memoryWriteValue,
  output logic [LineWidth-1:0] memoryReadValue,
  output logic                 memoryDone,
  output logic [31:0]          readCount,
  output logic [31:0]          writeCount
);

  localparam int unsigned Depth    = 1 << DepthLog2;
  localparam int unsigned CntWidth = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [CntWidth-1:0]   cnt, cnt_nxt;
  logic [DepthLog2-1:0]  addr_q;
  logic                  is_write_q;
  logic [LineWidth-1:0]  wdata_q;
  logic [DepthLog2-1:0]  addr_idx_c;
  logic [DepthLog2-1:0]  req_addr_c;
  logic                  req_write_c;

  logic [LineWidth-1:0]  mem [Depth];

  // Truncates to the index width, or zero-extends when the array is wider than the address.
  assign addr_idx_c = DepthLog2'(memoryAddr);

  // With Latency==1 RESP is entered straight from IDLE, before the request is latched.
  assign req_addr_c  = (state == IDLE) ? addr_idx_c    : addr_q;
  assign req_write_c = (state == IDLE) ? memoryIsWrite : is_write_q;

  // Next-state and countdown
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (memoryEnable) begin
          if (Latency == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CntWidth'(Latency - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CntWidth'(1);
        if (cnt == CntWidth'(1)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, response and completion counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      memoryDone      <= 1'b0;
      memoryReadValue <= '0;
      readCount       <= '0;
      writeCount      <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      memoryDone <= (state_nxt == RESP);
      if (state != RESP && state_nxt == RESP && !req_write_c) begin
        memoryReadValue <= mem[req_addr_c];
      end
      if (state == RESP) begin
        if (is_write_q) writeCount <= writeCount + 32'd1;
        else            readCount  <= readCount + 32'd1;
      end
    end
  end

  // Request capture, only at acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && memoryEnable) begin
      addr_q     <= addr_idx_c;
      is_write_q <= memoryIsWrite;
      wdata_q    <= memoryWriteValue;
    end
  end

  // Write commits on the edge leaving RESP; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (rst && state == RESP && is_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: a Latency=4 / 4096-line instance
// and a Latency=1 / 16-line instance sharing one clock and reset.
module tb_line_memory_responder;

  localparam int unsigned AW = 30;
  localparam int unsigned LW = 128;

  localparam logic [LW-1:0] DA5 = {16{8'hA5}};
  localparam logic [LW-1:0] DX  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LW-1:0] DY  = {4{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] DZ  = {2{64'h1111_2222_3333_4444}};
  localparam logic [LW-1:0] DW  = {LW{1'b1}};
  localparam logic [LW-1:0] DL0 = 128'h0000_0000_0000_0000_0000_0000_CAFE_0000;
  localparam logic [LW-1:0] DL1 = 128'h0BAD_F00D_0000_0000_0000_0000_0000_0001;
  localparam logic [LW-1:0] DV  = 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] a4, a1;
  logic          en4, en1, wr4, wr1;
  logic [LW-1:0] wd4, wd1, rv4, rv1;
  logic          dn4, dn1;
  logic [31:0]   rc4, wc4, rc1, wc1;

  int errors = 0;
  int checks = 0;

  line_memory_responder #(.AddrWidth(AW), .LineWidth(LW), .DepthLog2(12), .Latency(4)) dut4 (
    .clk(clk), .rst(rst), .memoryAddr(a4), .memoryEnable(en4), .memoryIsWrite(wr4),
    .memoryWriteValue(wd4), .memoryReadValue(rv4), .memoryDone(dn4),
    .readCount(rc4), .writeCount(wc4));

  line_memory_responder #(.AddrWidth(AW), .LineWidth(LW), .DepthLog2(4), .Latency(1)) dut1 (
    .clk(clk), .rst(rst), .memoryAddr(a1), .memoryEnable(en1), .memoryIsWrite(wr1),
    .memoryWriteValue(wd1), .memoryReadValue(rv1), .memoryDone(dn1),
    .readCount(rc1), .writeCount(wc1));

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the Latency=4 instance; done must appear only in the 4th cycle.
  task automatic req4(input string tag, input logic [AW-1:0] addr, input logic w,
                      input logic [LW-1:0] d, input logic [LW-1:0] exp_rd, input logic scr);
    @(negedge clk);
    a4 = addr; wr4 = w; wd4 = d; en4 = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("%s done c%0d", tag, i), LW'(dn4), LW'(i == 3));
      if (i >= 3 && !w) check($sformatf("%s rdata c%0d", tag, i), rv4, exp_rd);
      if (scr && i < 3) begin
        a4  = AW'($urandom);
        wr4 = 1'($urandom);
        wd4 = {$urandom(), $urandom(), $urandom(), $urandom()};
        en4 = 1'b1;
      end else begin
        en4 = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    en4 = 1'b0; wr4 = 1'b0; a4 = '0; wd4 = '0;
    en1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst done4", LW'(dn4), '0);
    check("rst rdata4", rv4, '0);
    check("rst rcnt4", LW'(rc4), '0);
    check("rst wcnt4", LW'(wc4), '0);
    check("rst done1", LW'(dn1), '0);
    dut4.mem[12'h020] = DY;
    dut1.mem[0] = DL0;
    dut1.mem[1] = DL1;
    rst = 1'b1;

    // Latency=1: back-to-back reads with enable held high
    @(negedge clk);
    a1 = '0; wr1 = 1'b0; en1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("l1 done0", LW'(dn1), LW'(1));
    check("l1 line0", rv1, DL0);
    a1 = AW'(1);
    @(negedge clk);
    check("l1 idle gap", LW'(dn1), '0);
    @(negedge clk);
    check("l1 done1", LW'(dn1), LW'(1));
    check("l1 line1", rv1, DL1);
    en1 = 1'b0;
    @(negedge clk);
    check("l1 done low", LW'(dn1), '0);
    check("l1 rcnt", LW'(rc1), LW'(2));

    // Latency=1: write line 5, read it back through an aliased address
    a1 = AW'(5); wr1 = 1'b1; wd1 = DV; en1 = 1'b1;
    @(negedge clk);
    check("l1 wr done", LW'(dn1), LW'(1));
    en1 = 1'b0;
    @(negedge clk);
    check("l1 wcnt", LW'(wc1), LW'(1));
    check("l1 rdata hold", rv1, DL1);
    a1 = AW'(32'h15); wr1 = 1'b0; en1 = 1'b1;
    @(negedge clk);
    check("l1 alias rd", rv1, DV);
    en1 = 1'b0;

    // Latency=4: write then read the same line
    req4("t1 wr", AW'(32'h10), 1'b1, DA5, '0, 1'b0);
    check("t1 wcnt", LW'(wc4), LW'(1));
    check("t1 rcnt", LW'(rc4), '0);
    req4("t1 rd", AW'(32'h10), 1'b0, '0, DA5, 1'b0);
    check("t1 rcnt2", LW'(rc4), LW'(1));

    // Aliasing modulo 4096 lines; writes leave the read register alone
    req4("t3 wr", AW'(32'h1003), 1'b1, DX, '0, 1'b0);
    check("t3 rdata hold", rv4, DA5);
    req4("t3 rd", AW'(32'h0003), 1'b0, '0, DX, 1'b0);
    check("t3 rcnt", LW'(rc4), LW'(2));

    // Inputs scrambled while waiting must not disturb the latched request
    req4("t5 wr", AW'(32'h55), 1'b1, DZ, '0, 1'b1);
    req4("t5 rd", AW'(32'h55), 1'b0, '0, DZ, 1'b1);
    check("t5 wcnt", LW'(wc4), LW'(3));
    check("t5 rcnt", LW'(rc4), LW'(3));

    // Reset while a write is waiting: nothing completes, nothing is committed
    @(negedge clk);
    a4 = AW'(32'h20); wr4 = 1'b1; wd4 = DW; en4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en4 = 1'b0; rst = 1'b0;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4 done c%0d", i), LW'(dn4), '0);
    end
    check("t4 rcnt", LW'(rc4), '0);
    check("t4 wcnt", LW'(wc4), '0);
    check("t4 rdata", rv4, '0);
    rst = 1'b1;
    req4("t4 rd", AW'(32'h20), 1'b0, '0, DY, 1'b0);
    check("t4 rcnt2", LW'(rc4), LW'(1));

    // Write counter wraps to zero
    @(negedge clk);
    dut4.writeCount = 32'hFFFF_FFFF;
    req4("t6 wr", AW'(32'h30), 1'b1, DV, '0, 1'b0);
    check("t6 wcnt wrap", LW'(wc4), '0);
    check("t6 rcnt", LW'(rc4), LW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
